// File: rtl/clock_divider.sv
// clock_divider: clk_out = clk_in / DIVIDE from a free-running modulo counter and registered phase bit; clk-to-q latency, no backpressure.
// Define CLOCK_DIVIDER_ODD_DUTY_EN to add a falling-edge stage that gives odd ratios an exact 50% duty cycle.
module clock_divider #(
    parameter int DIVIDE    = 2,
    parameter int ASYNC_RST = 1
) (
    input  logic clk_in,
    input  logic rst,
    output logic clk_out
);
    localparam int CW = (DIVIDE < 2) ? 1 : $clog2(DIVIDE);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIVIDE - 1);
    localparam logic [CW-1:0] HALF    = CW'(DIVIDE / 2);

    if (DIVIDE < 2) begin : g_bad_divide
        $fatal(1, "clock_divider: DIVIDE must be >= 2, got %0d", DIVIDE);
    end

    // Legacy parameter kept for drop-in compatibility; reset is synchronous regardless.
    if (ASYNC_RST != 0) begin : g_async_rst_ignored
    end

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          p;

    always_comb begin
        cnt_next = (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt <= '0;
            p   <= 1'b0;
        end else begin
            cnt <= cnt_next;
            p   <= (cnt_next >= HALF);
        end
    end

`ifdef CLOCK_DIVIDER_ODD_DUTY_EN
    if (DIVIDE % 2 == 1) begin : g_odd_duty
        logic n;

        // n trails p by half a cycle, trimming half an input period off the high phase.
        always_ff @(negedge clk_in) begin
            if (rst) begin
                n <= 1'b0;
            end else begin
                n <= p;
            end
        end

        assign clk_out = p & n;
    end else begin : g_even
        assign clk_out = p;
    end
`else
    assign clk_out = p;
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider: DIVIDE = 2, 3 and 4 side by side, checked half-cycle by half-cycle against a timing model.
module tb_clock_divider;
    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    logic out2;
    logic out3;
    logic out4;

    int checks = 0;
    int errors = 0;
    int k      = 0;
    logic [2:0] exp_q[$];

    always #5 clk_in = ~clk_in;

    clock_divider #(.DIVIDE(2), .ASYNC_RST(1)) u_div2 (.clk_in(clk_in), .rst(rst), .clk_out(out2));
    clock_divider #(.DIVIDE(3), .ASYNC_RST(0)) u_div3 (.clk_in(clk_in), .rst(rst), .clk_out(out3));
    clock_divider #(.DIVIDE(4), .ASYNC_RST(1)) u_div4 (.clk_in(clk_in), .rst(rst), .clk_out(out4));

    // Expected clk_out after rising edge kk (kk = 0 means reset was sampled);
    // late = 1 selects the half period after the following falling edge.
    function automatic logic model(input int d, input int kk, input bit late);
        int m;
        if (kk == 0) return 1'b0;
        m = kk % d;
`ifdef CLOCK_DIVIDER_ODD_DUTY_EN
        if (d % 2 == 1) begin
            if (late) return (m >= d / 2);
            return (m >= d / 2 + 1);
        end
`endif
        return (m >= d / 2);
    endfunction

    task automatic step(input logic r, input string tag);
        logic [2:0] got;
        logic [2:0] e;
        rst = r;
        if (r) k = 0;
        else   k++;
        exp_q.push_back({model(4, k, 1'b0), model(3, k, 1'b0), model(2, k, 1'b0)});
        exp_q.push_back({model(4, k, 1'b1), model(3, k, 1'b1), model(2, k, 1'b1)});
        @(posedge clk_in);
        #2;
        got = {out4, out3, out2};
        e   = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s edge %0d first half: clk_out{d4,d3,d2} got %b expected %b", tag, k, got, e);
        end
        @(negedge clk_in);
        #2;
        got = {out4, out3, out2};
        e   = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s edge %0d second half: clk_out{d4,d3,d2} got %b expected %b", tag, k, got, e);
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 1000; i++) step(1'b1, "reset_hold");
    endtask

    task automatic test_divide_all;
        for (int i = 0; i < 24; i++) step(1'b0, "divide_run");
    endtask

    task automatic test_divide4_cnt;
        logic [1:0] exp_cnt;
        step(1'b1, "cnt_reset");
        for (int i = 0; i < 8; i++) begin
            step(1'b0, "cnt_run");
            exp_cnt = 2'(k % 4);
            checks++;
            if (u_div4.cnt !== exp_cnt) begin
                errors++;
                $display("FAIL cnt_seq edge %0d: cnt got %0d expected %0d", k, u_div4.cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_midperiod_reset;
        step(1'b1, "mid_pre");
        step(1'b0, "mid_run");
        step(1'b0, "mid_run");
        checks++;
        if (out4 !== 1'b1) begin
            errors++;
            $display("FAIL mid_high: d4 clk_out got %b expected 1", out4);
        end
        step(1'b1, "mid_trunc");
        checks++;
        if (out4 !== 1'b0) begin
            errors++;
            $display("FAIL mid_trunc: d4 clk_out got %b expected 0", out4);
        end
        for (int i = 0; i < 10; i++) step(1'b0, "mid_restart");
    endtask

    task automatic test_back_to_back;
        int hold;
        int run;
        for (int t = 0; t < 20; t++) begin
            hold = $urandom_range(1, 3);
            run  = $urandom_range(1, 14);
            for (int i = 0; i < hold; i++) step(1'b1, "b2b_reset");
            for (int i = 0; i < run; i++) step(1'b0, "b2b_run");
        end
    endtask

    initial begin
        test_reset;
        test_divide_all;
        test_divide4_cnt;
        test_midperiod_reset;
        test_back_to_back;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
